fp_mul_div_seq: RTL and testbench

Parametrised, handshaked successor to mul_div. Performs IEEE-754-style floating-point multiply or divide on a configurable exponent/mantissa format. Multiply uses a single-cycle mantissa product; divide uses an iterative restoring divider. Sits between an operand-issue stage (valid/ready) and a result consumer (valid/ready), and reports the same five exception flags as mul_div.

---
 rtl/fp_mul_div_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fp_mul_div_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fp_mul_div_seq.sv
// Sequential IEEE-754-style floating-point multiply / divide with valid/ready handshakes.
// Multiply uses a one-cycle mantissa product; divide uses a restoring divider.
module fp_mul_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sel,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   R,
  output logic                   io_flag,
  output logic                   dz_flag,
  output logic                   of_flag,
  output logic                   uf_flag,
  output logic                   i_flag,
  output logic [2:0]             dbg_state
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic [CW-1:0]        LAST    = CW'(MAN_W + 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_DIV   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state;
  logic [W-1:0]           a_r, b_r;
  logic                   sel_r;
  logic signed [XW-1:0]   exp_r;
  logic [PW-1:0]          prod_r;
  logic [MAN_W+1:0]       q_r;
  logic [MAN_W+1:0]       rem_r;
  logic [CW-1:0]          cnt;

  assign dbg_state = state;

  // Operand fields of the latched pair; subnormals are classified as zero.
  logic             sa, sb, sign_c;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa     = a_r[W-1];
  assign sb     = b_r[W-1];
  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign fa     = a_r[MAN_W-1:0];
  assign fb     = b_r[MAN_W-1:0];
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign sign_c = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);

  logic [W-1:0] inf_c, zero_c;
  assign inf_c  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_c = {sign_c, {(W-1){1'b0}}};

  logic signed [XW-1:0] ea_x, eb_x, mul_exp, div_exp;
  assign ea_x    = {2'b00, ea};
  assign eb_x    = {2'b00, eb};
  assign mul_exp = ea_x + eb_x - BIAS;
  assign div_exp = ea_x - eb_x + BIAS;

  logic [PW-1:0] prod_c;
  assign prod_c = {{(MAN_W+1){1'b0}}, ma} * {{(MAN_W+1){1'b0}}, mb};

  logic             rem_ge;
  logic [MAN_W+1:0] rem_nxt;
  assign rem_ge  = (rem_r >= {1'b0, mb});
  assign rem_nxt = rem_ge ? (rem_r - {1'b0, mb}) : rem_r;

  logic         spec_hit, spec_io, spec_dz;
  logic [W-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_io  = 1'b0;
    spec_dz  = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
      spec_io  = 1'b1;
    end else if (!sel_r) begin
      if ((a_zero && b_inf) || (a_inf && b_zero)) begin
        spec_res = QNAN;
        spec_io  = 1'b1;
      end else if (a_inf || b_inf) begin
        spec_res = inf_c;
      end else if (a_zero || b_zero) begin
        spec_res = zero_c;
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_res = QNAN;
        spec_io  = 1'b1;
      end else if (a_inf) begin
        spec_res = inf_c;
      end else if (b_zero) begin
        spec_res = inf_c;
        spec_dz  = 1'b1;
      end else if (b_inf || a_zero) begin
        spec_res = zero_c;
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // Product lies in [1,4) and quotient in (0.5,2): at most one shift either way.
  logic signed [XW-1:0] norm_exp;
  logic [MAN_W-1:0]     norm_frac;
  logic                 norm_lost, norm_of, norm_uf;

  always_comb begin
    norm_exp  = exp_r;
    norm_frac = '0;
    norm_lost = 1'b0;
    if (!sel_r) begin
      if (prod_r[PW-1]) begin
        norm_frac = prod_r[PW-2 -: MAN_W];
        norm_lost = |prod_r[MAN_W:0];
        norm_exp  = exp_r + ONE;
      end else begin
        norm_frac = prod_r[PW-3 -: MAN_W];
        norm_lost = |prod_r[MAN_W-1:0];
      end
    end else begin
      if (q_r[MAN_W+1]) begin
        norm_frac = q_r[MAN_W:1];
        norm_lost = q_r[0] | (|rem_r);
      end else begin
        norm_frac = q_r[MAN_W-1:0];
        norm_lost = |rem_r;
        norm_exp  = exp_r - ONE;
      end
    end
  end

  assign norm_of = (norm_exp >= EXP_MAX);
  assign norm_uf = norm_exp[XW-1] || (norm_exp == '0);

  // Handshake: a transfer happens on a rising edge with en=1 and both valid and
  // ready high; in_ready is high only in IDLE, out_valid only in DONE.
  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      R         <= '0;
      io_flag   <= 1'b0;
      dz_flag   <= 1'b0;
      of_flag   <= 1'b0;
      uf_flag   <= 1'b0;
      i_flag    <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sel_r     <= 1'b0;
      exp_r     <= '0;
      prod_r    <= '0;
      q_r       <= '0;
      rem_r     <= '0;
      cnt       <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            sel_r    <= sel;
            in_ready <= 1'b0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (spec_hit) begin
            R         <= spec_res;
            io_flag   <= spec_io;
            dz_flag   <= spec_dz;
            of_flag   <= 1'b0;
            uf_flag   <= 1'b0;
            i_flag    <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (sel_r) begin
            exp_r <= div_exp;
            rem_r <= {1'b0, ma};
            q_r   <= '0;
            cnt   <= '0;
            state <= S_DIV;
          end else begin
            exp_r <= mul_exp;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod_r <= prod_c;
          state  <= S_NORM;
        end
        S_DIV: begin
          q_r   <= {q_r[MAN_W:0], rem_ge};
          rem_r <= rem_nxt << 1;
          if (cnt == LAST) state <= S_NORM;
          else             cnt   <= cnt + 1'b1;
        end
        S_NORM: begin
          io_flag <= 1'b0;
          dz_flag <= 1'b0;
          if (norm_of) begin
            R       <= inf_c;
            of_flag <= 1'b1;
            uf_flag <= 1'b0;
            i_flag  <= 1'b1;
          end else if (norm_uf) begin
            R       <= zero_c;
            of_flag <= 1'b0;
            uf_flag <= 1'b1;
            i_flag  <= 1'b1;
          end else begin
            R       <= {sign_c, norm_exp[EXP_W-1:0], norm_frac};
            of_flag <= 1'b0;
            uf_flag <= 1'b0;
            i_flag  <= norm_lost;
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_div_seq.sv
// Directed bench for fp_mul_div_seq (binary32): driver pushes expected {R, flags},
// a negedge monitor pops and compares on every accepted result.
module tb_fp_mul_div_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         arst, en, in_valid, in_ready, sel, out_valid, out_ready;
  logic [W-1:0] a, b, R;
  logic         io_flag, dz_flag, of_flag, uf_flag, i_flag;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W+4:0] exp_q[$];

  // flag vector order: {io, dz, of, uf, i}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_IO   = 5'b10000;
  localparam logic [4:0] F_DZ   = 5'b01000;
  localparam logic [4:0] F_OFI  = 5'b00101;
  localparam logic [4:0] F_UFI  = 5'b00011;
  localparam logic [4:0] F_I    = 5'b00001;

  fp_mul_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .arst(arst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .io_flag(io_flag), .dz_flag(dz_flag), .of_flag(of_flag),
    .uf_flag(uf_flag), .i_flag(i_flag), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: a result is consumed on the next edge whenever valid && ready && en.
  always @(negedge clk) begin : monitor
    logic [W+4:0] got, want;
    if (en && !arst && out_valid && out_ready) begin
      got = {R, io_flag, dz_flag, of_flag, uf_flag, i_flag};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%h want=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL result got R=%h flags=%b want R=%h flags=%b",
                   got[W+4:5], got[4:0], want[W+4:5], want[4:0]);
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_in_ready"}, in_ready, 1);
  endtask

  // Issue one operation; optionally freeze en for 4 cycles and/or stall out_ready.
  task automatic issue(input string nm, input logic s, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] er,
                       input logic [4:0] ef, input int lat, input int stall_at,
                       input int hold);
    int cyc;
    wait_ready(nm);
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    if (hold > 0) out_ready = 1'b0;
    exp_q.push_back({er, ef});
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      en = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 4);
      in_valid = (cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    en = 1'b1;
    in_valid = 1'b0;
    check({nm, "_latency"}, cyc, lat);
    for (int i = 0; i < hold; i++) begin
      check({nm, "_hold_R"}, R, er);
      check({nm, "_hold_flags"}, {io_flag, dz_flag, of_flag, uf_flag, i_flag}, ef);
      check({nm, "_hold_in_ready"}, in_ready, 0);
      check({nm, "_hold_out_valid"}, out_valid, 1);
      in_valid = (i == 2);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int n;
    arst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sel = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_R", R, 0);
    check("reset_flags", {io_flag, dz_flag, of_flag, uf_flag, i_flag}, 0);

    issue("mul_3x2",      0, 32'h40400000, 32'h40000000, 32'h40C00000, F_NONE, 3, -1, 0);
    issue("div_1by3",     1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_I,   27, -1, 0);
    issue("div_1by0",     1, 32'h3F800000, 32'h00000000, 32'h7F800000, F_DZ,   1, -1, 0);
    issue("mul_0xinf",    0, 32'h00000000, 32'h7F800000, 32'h7FC00000, F_IO,   1, -1, 0);
    issue("mul_overflow", 0, 32'h7F000000, 32'h7F000000, 32'h7F800000, F_OFI,  3, -1, 0);
    issue("mul_underflow",0, 32'h00800000, 32'h00800000, 32'h00000000, F_UFI,  3, -1, 0);
    issue("div_6by2",     1, 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE,27, -1, 0);
    issue("mul_neg",      0, 32'hC0000000, 32'h40400000, 32'hC0C00000, F_NONE, 3, -1, 0);
    issue("mul_inexact",  0, 32'h3F800001, 32'h3F800001, 32'h3F800002, F_I,    3, -1, 0);
    issue("mul_nan_in",   0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_IO,   1, -1, 0);
    issue("div_infinf",   1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, F_IO,   1, -1, 0);
    issue("div_fin_inf",  1, 32'h3F800000, 32'hFF800000, 32'h80000000, F_NONE, 1, -1, 0);
    issue("mul_subnorm",  0, 32'h00000001, 32'h3F800000, 32'h00000000, F_NONE, 1, -1, 0);
    issue("mul_inf_fin",  0, 32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, 1, -1, 0);
    issue("div_0by0",     1, 32'h80000000, 32'h00000000, 32'h7FC00000, F_IO,   1, -1, 0);
    issue("div_0by_fin",  1, 32'h00000000, 32'hC0000000, 32'h80000000, F_NONE, 1, -1, 0);
    issue("div_inf_by0",  1, 32'h7F800000, 32'h00000000, 32'h7F800000, F_NONE, 1, -1, 0);
    issue("div_overflow", 1, 32'h7F000000, 32'h00800000, 32'h7F800000, F_OFI, 27, -1, 0);
    issue("div_underflow",1, 32'h00800000, 32'h7F000000, 32'h00000000, F_UFI, 27, -1, 0);
    issue("handshake",    0, 32'h40400000, 32'h40000000, 32'h40C00000, F_NONE, 3, -1, 5);
    issue("div_en_stall", 1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_I,   31, 10, 0);

    // Reset in the middle of a divide discards it.
    wait_ready("div_reset");
    sel = 1'b1; a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_R", R, 0);
    check("midreset_flags", {io_flag, dz_flag, of_flag, uf_flag, i_flag}, 0);

    issue("post_reset_mul", 0, 32'hC0000000, 32'h40400000, 32'hC0C00000, F_NONE, 3, -1, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
